// File: rtl/jpeg_block_sipo.sv
// Serial-in/parallel-out 8x8 coefficient block assembler with optional zigzag-to-raster
// reordering; presents the full block on a packed bus until the consumer takes it.
module jpeg_block_sipo #(
  parameter int unsigned DW     = 16,
  parameter bit          ZIGZAG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [64*DW-1:0] blk_q,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [5:0]       cnt
);

  localparam int unsigned NSLOT = 64;
  localparam int unsigned CW    = 6;
  localparam int unsigned BW    = NSLOT * DW;

  typedef logic [NSLOT-1:0][CW-1:0] lut_t;
  typedef enum logic {COLLECT, PRESENT} state_e;

  // Walk the 15 anti-diagonals, alternating direction, to get zigzag index -> raster slot.
  function automatic lut_t build_zz();
    lut_t t;
    int   n;
    int   r;
    int   c;
    t = '0;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int i = 0; i < 8; i++) begin
        if ((s % 2) == 0) r = ((s < 8) ? s : 7) - i;
        else              r = ((s < 8) ? 0 : s - 7) + i;
        c = s - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8 && n < 64) begin
          t[n[5:0]] = CW'(r * 8 + c);
          n++;
        end
      end
    end
    return t;
  endfunction

  localparam lut_t ZZ_LUT = build_zz();

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   blk_d;
  logic            din_ready_q, din_ready_d;
  logic            blk_valid_q, blk_valid_d;
  logic            accept;
  logic [CW-1:0]   slot;

  // Next-state, slot write and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    accept      = din_valid & din_ready_q;
    slot        = ZIGZAG ? ZZ_LUT[cnt_q] : cnt_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int k = 0; k < 64; k++) begin
            if (slot == CW'(k)) blk_d[k*DW +: DW] = din;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(63)) state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (blk_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    din_ready_d = (state_d == COLLECT);
    blk_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      blk_q       <= '0;
      din_ready_q <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      din_ready_q <= din_ready_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  assign din_ready = din_ready_q;
  assign blk_valid = blk_valid_q;
  assign cnt       = cnt_q;

endmodule
